// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage pipeline register: DEPTH chained slots of {valid, ctrl, data}
// with global stall, entry-slot flush, full flush and a saturating bubble counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned CTRL_W     = 16,
  parameter int unsigned DEPTH      = 1,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              flush,
  input  logic              flush_all,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [DEPTH-1:0]             v_q, v_d;
  logic [DEPTH-1:0][CTRL_W-1:0] c_q, c_d;
  logic [DEPTH-1:0][DATA_W-1:0] d_q, d_d;
  logic [CNT_W-1:0]             cnt_q;

  // Slot update with precedence flush_all > flush (slot 0 only) > stall > shift.
  always_comb begin
    // NOTE: every combinational output is given a default first so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    v_d = v_q;
    c_d = c_q;
    d_d = d_q;
    if (flush_all) begin
      v_d = '0;
      c_d = '0;
      if (CLEAR_DATA) d_d = '0;
    end else begin
      if (!stall) begin
        for (int k = DEPTH - 1; k > 0; k--) begin
          v_d[k] = v_q[k-1];
          c_d[k] = c_q[k-1];
          d_d[k] = d_q[k-1];
        end
      end
      if (flush) begin
        v_d[0] = 1'b0;
        c_d[0] = '0;
        if (CLEAR_DATA) d_d[0] = '0;
      end else if (!stall) begin
        // An invalid input still enters as a bubble carrying its data, but never its ctrl.
        v_d[0] = in_valid;
        c_d[0] = in_valid ? in_ctrl : '0;
        d_d[0] = in_data;
      end
    end
  end

  // NOTE: the data slots are ordinary flops, so they are reset along with valid and
  // ctrl; a reset must leave out_data at 0 even when CLEAR_DATA=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples
      // the pre-edge values regardless of statement order.
      v_q <= '0;
      c_q <= '0;
      d_q <= '0;
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      d_q <= d_d;
    end
  end

  // Counts edges where the output slot was a bubble; clear wins, no wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (cnt_clr) begin
      cnt_q <= '0;
    end else if (!v_q[DEPTH-1] && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + CNT_ONE;
    end
  end

  assign out_valid  = v_q[DEPTH-1];
  assign out_ctrl   = v_q[DEPTH-1] ? c_q[DEPTH-1] : '0;
  assign out_data   = d_q[DEPTH-1];
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for pipe_stage_reg: several parameterisations share one input bus,
// each scenario task drives vectors and compares against hand-computed values.
module tb_pipe_stage_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, flush_all = 1'b0, cnt_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_ctrl = '0;
  logic [31:0] in_data = '0;

  logic        d3_valid, d2_valid, d1c_valid, d1k_valid, d4_valid;
  logic [15:0] d3_ctrl, d2_ctrl, d1c_ctrl, d1k_ctrl, d4_ctrl;
  logic [31:0] d3_data, d2_data, d1c_data, d1k_data, d4_data;
  logic [15:0] d3_cnt, d2_cnt, d1c_cnt, d1k_cnt;
  logic [3:0]  d4_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pipe_stage_reg #(.DEPTH(3)) u_d3 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_all(flush_all),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(d3_valid), .out_ctrl(d3_ctrl), .out_data(d3_data),
    .cnt_clr(cnt_clr), .bubble_cnt(d3_cnt));

  pipe_stage_reg #(.DEPTH(2)) u_d2 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_all(flush_all),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(d2_valid), .out_ctrl(d2_ctrl), .out_data(d2_data),
    .cnt_clr(cnt_clr), .bubble_cnt(d2_cnt));

  pipe_stage_reg #(.DEPTH(1), .CLEAR_DATA(1'b1)) u_d1c (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_all(flush_all),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(d1c_valid), .out_ctrl(d1c_ctrl), .out_data(d1c_data),
    .cnt_clr(cnt_clr), .bubble_cnt(d1c_cnt));

  pipe_stage_reg #(.DEPTH(1), .CLEAR_DATA(1'b0)) u_d1k (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_all(flush_all),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(d1k_valid), .out_ctrl(d1k_ctrl), .out_data(d1k_data),
    .cnt_clr(cnt_clr), .bubble_cnt(d1k_cnt));

  pipe_stage_reg #(.DEPTH(4), .CNT_W(4)) u_d4 (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_all(flush_all),
    .in_valid(in_valid), .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(d4_valid), .out_ctrl(d4_ctrl), .out_data(d4_data),
    .cnt_clr(cnt_clr), .bubble_cnt(d4_cnt));

  // Advance one rising edge and settle 1 ns past it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse reset between edges and return all controls to idle.
  task automatic do_reset();
    stall = 1'b0; flush = 1'b0; flush_all = 1'b0; cnt_clr = 1'b0;
    in_valid = 1'b0; in_ctrl = '0; in_data = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [15:0] c, input logic [31:0] d);
    in_valid = v; in_ctrl = c; in_data = d;
  endtask

  task automatic test_reset();
    #2;
    n_checks++; if (d3_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", d3_valid); end
    n_checks++; if (d3_ctrl !== 16'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h want 0", d3_ctrl); end
    n_checks++; if (d1k_data !== 32'h0) begin n_fail++; $display("FAIL reset_data_keep: got %h want 0", d1k_data); end
    n_checks++; if (d3_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0", d3_cnt); end
    tick();
    n_checks++; if (d3_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_held_cnt: got %h want 0", d3_cnt); end
    rst = 1'b0;
    tick();
    n_checks++; if (d3_cnt !== 16'h1) begin n_fail++; $display("FAIL first_edge_cnt: got %h want 1", d3_cnt); end
  endtask

  task automatic test_streaming();
    do_reset();
    drive(1'b1, 16'h0110, 32'h10); tick();
    n_checks++; if (d3_valid !== 1'b0) begin n_fail++; $display("FAIL stream_early_valid: got %b want 0", d3_valid); end
    drive(1'b1, 16'h0111, 32'h11); tick();
    n_checks++; if (d3_ctrl !== 16'h0) begin n_fail++; $display("FAIL stream_early_ctrl: got %h want 0", d3_ctrl); end
    drive(1'b1, 16'h0112, 32'h12); tick();
    n_checks++; if (d3_data !== 32'h10) begin n_fail++; $display("FAIL stream_e3_data: got %h want 10", d3_data); end
    n_checks++; if (d3_valid !== 1'b1) begin n_fail++; $display("FAIL stream_e3_valid: got %b want 1", d3_valid); end
    n_checks++; if (d3_ctrl !== 16'h0110) begin n_fail++; $display("FAIL stream_e3_ctrl: got %h want 0110", d3_ctrl); end
    n_checks++; if (d3_cnt !== 16'd3) begin n_fail++; $display("FAIL stream_e3_cnt: got %0d want 3", d3_cnt); end
    drive(1'b1, 16'h0113, 32'h13); tick();
    n_checks++; if (d3_data !== 32'h11) begin n_fail++; $display("FAIL stream_e4_data: got %h want 11", d3_data); end
    drive(1'b1, 16'h0114, 32'h14); tick();
    n_checks++; if (d3_data !== 32'h12) begin n_fail++; $display("FAIL stream_e5_data: got %h want 12", d3_data); end
    n_checks++; if (d3_ctrl !== 16'h0112) begin n_fail++; $display("FAIL stream_e5_ctrl: got %h want 0112", d3_ctrl); end
    n_checks++; if (d3_cnt !== 16'd3) begin n_fail++; $display("FAIL stream_cnt_hold: got %0d want 3", d3_cnt); end
    // Invalid input: bubble carries data but never ctrl.
    drive(1'b0, 16'hBEEF, 32'h15);
    tick(); tick(); tick();
    n_checks++; if (d3_valid !== 1'b0) begin n_fail++; $display("FAIL bubble_valid: got %b want 0", d3_valid); end
    n_checks++; if (d3_ctrl !== 16'h0) begin n_fail++; $display("FAIL bubble_ctrl: got %h want 0", d3_ctrl); end
    n_checks++; if (d3_data !== 32'h15) begin n_fail++; $display("FAIL bubble_data: got %h want 15", d3_data); end
  endtask

  task automatic test_stall();
    do_reset();
    drive(1'b1, 16'h00AA, 32'hAA); tick();
    drive(1'b1, 16'h00BB, 32'hBB); tick();
    n_checks++; if (d2_data !== 32'hAA) begin n_fail++; $display("FAIL stall_pre_data: got %h want aa", d2_data); end
    drive(1'b1, 16'h00CC, 32'hCC);
    stall = 1'b1;
    tick();
    n_checks++; if (d2_data !== 32'hAA) begin n_fail++; $display("FAIL stall_e1_data: got %h want aa", d2_data); end
    tick();
    n_checks++; if (d2_data !== 32'hAA) begin n_fail++; $display("FAIL stall_e2_data: got %h want aa", d2_data); end
    n_checks++; if (d2_ctrl !== 16'h00AA) begin n_fail++; $display("FAIL stall_e2_ctrl: got %h want 00aa", d2_ctrl); end
    n_checks++; if (d2_cnt !== 16'd2) begin n_fail++; $display("FAIL stall_cnt: got %0d want 2", d2_cnt); end
    stall = 1'b0;
    tick();
    n_checks++; if (d2_data !== 32'hBB) begin n_fail++; $display("FAIL stall_release_data: got %h want bb", d2_data); end
    tick();
    n_checks++; if (d2_data !== 32'hCC) begin n_fail++; $display("FAIL stall_next_data: got %h want cc", d2_data); end
  endtask

  task automatic test_flush_stall();
    do_reset();
    drive(1'b1, 16'h00FF, 32'h55); tick();
    n_checks++; if (d1c_ctrl !== 16'h00FF) begin n_fail++; $display("FAIL fs_load_ctrl: got %h want 00ff", d1c_ctrl); end
    n_checks++; if (d1c_data !== 32'h55) begin n_fail++; $display("FAIL fs_load_data: got %h want 55", d1c_data); end
    drive(1'b1, 16'h00FF, 32'h66);
    flush = 1'b1; stall = 1'b1;
    tick();
    n_checks++; if (d1c_valid !== 1'b0) begin n_fail++; $display("FAIL fs_valid: got %b want 0", d1c_valid); end
    n_checks++; if (d1c_ctrl !== 16'h0) begin n_fail++; $display("FAIL fs_ctrl: got %h want 0", d1c_ctrl); end
    n_checks++; if (d1c_data !== 32'h0) begin n_fail++; $display("FAIL fs_data_clear: got %h want 0", d1c_data); end
    n_checks++; if (d1k_valid !== 1'b0) begin n_fail++; $display("FAIL fs_valid_keep: got %b want 0", d1k_valid); end
    n_checks++; if (d1k_data !== 32'h55) begin n_fail++; $display("FAIL fs_data_keep: got %h want 55", d1k_data); end
    flush = 1'b0; stall = 1'b0;
    tick();
    n_checks++; if (d1k_data !== 32'h66) begin n_fail++; $display("FAIL fs_resume_data: got %h want 66", d1k_data); end
    n_checks++; if (d1k_ctrl !== 16'h00FF) begin n_fail++; $display("FAIL fs_resume_ctrl: got %h want 00ff", d1k_ctrl); end
  endtask

  task automatic test_flush_timing();
    do_reset();
    drive(1'b1, 16'h0201, 32'h1); tick();
    drive(1'b1, 16'h0202, 32'h2); tick();
    drive(1'b1, 16'h0203, 32'h3);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (d3_data !== 32'h1) begin n_fail++; $display("FAIL ft_e3_data: got %h want 1", d3_data); end
    n_checks++; if (d1c_valid !== 1'b0) begin n_fail++; $display("FAIL ft_depth1_valid: got %b want 0", d1c_valid); end
    drive(1'b1, 16'h0204, 32'h4); tick();
    n_checks++; if (d3_data !== 32'h2) begin n_fail++; $display("FAIL ft_e4_data: got %h want 2", d3_data); end
    drive(1'b1, 16'h0205, 32'h5); tick();
    n_checks++; if (d3_valid !== 1'b0) begin n_fail++; $display("FAIL ft_e5_valid: got %b want 0", d3_valid); end
    n_checks++; if (d3_ctrl !== 16'h0) begin n_fail++; $display("FAIL ft_e5_ctrl: got %h want 0", d3_ctrl); end
    n_checks++; if (d3_data !== 32'h0) begin n_fail++; $display("FAIL ft_e5_data: got %h want 0", d3_data); end
    drive(1'b1, 16'h0206, 32'h6); tick();
    n_checks++; if (d3_ctrl !== 16'h0204) begin n_fail++; $display("FAIL ft_e6_ctrl: got %h want 0204", d3_ctrl); end
  endtask

  task automatic test_flush_all();
    do_reset();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 16'h0300 + 16'(i), 32'(i));
      tick();
    end
    n_checks++; if (d4_data !== 32'h1) begin n_fail++; $display("FAIL fa_full_data: got %h want 1", d4_data); end
    n_checks++; if (d4_cnt !== 4'd4) begin n_fail++; $display("FAIL fa_full_cnt: got %0d want 4", d4_cnt); end
    drive(1'b1, 16'h0305, 32'h5);
    flush_all = 1'b1;
    tick();
    flush_all = 1'b0;
    n_checks++; if (d4_valid !== 1'b0) begin n_fail++; $display("FAIL fa_e5_valid: got %b want 0", d4_valid); end
    n_checks++; if (d4_data !== 32'h0) begin n_fail++; $display("FAIL fa_e5_data: got %h want 0", d4_data); end
    n_checks++; if (d4_cnt !== 4'd4) begin n_fail++; $display("FAIL fa_e5_cnt: got %0d want 4", d4_cnt); end
    drive(1'b0, 16'h0, 32'h99);
    for (int i = 6; i <= 8; i++) begin
      tick();
      n_checks++; if (d4_valid !== 1'b0) begin n_fail++; $display("FAIL fa_drain_valid e%0d: got %b want 0", i, d4_valid); end
    end
    n_checks++; if (d4_cnt !== 4'd7) begin n_fail++; $display("FAIL fa_drain_cnt: got %0d want 7", d4_cnt); end
  endtask

  task automatic test_cnt_saturation();
    do_reset();
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 15) begin
        n_checks++; if (d4_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_e15: got %0d want 15", d4_cnt); end
      end
    end
    n_checks++; if (d4_cnt !== 4'd15) begin n_fail++; $display("FAIL sat_e20: got %0d want 15", d4_cnt); end
    n_checks++; if (d3_cnt !== 16'd20) begin n_fail++; $display("FAIL wide_e20: got %0d want 20", d3_cnt); end
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
    n_checks++; if (d4_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_cnt: got %0d want 0", d4_cnt); end
    tick();
    n_checks++; if (d4_cnt !== 4'd1) begin n_fail++; $display("FAIL clr_then_inc: got %0d want 1", d4_cnt); end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 16'h0430, 32'h30); tick();
    drive(1'b1, 16'h0431, 32'h31); tick();
    drive(1'b1, 16'h0432, 32'h32); tick();
    n_checks++; if (d3_data !== 32'h30) begin n_fail++; $display("FAIL ar_pre_data: got %h want 30", d3_data); end
    #3 rst = 1'b1;
    #1;
    n_checks++; if (d3_valid !== 1'b0) begin n_fail++; $display("FAIL ar_valid: got %b want 0", d3_valid); end
    n_checks++; if (d3_ctrl !== 16'h0) begin n_fail++; $display("FAIL ar_ctrl: got %h want 0", d3_ctrl); end
    n_checks++; if (d3_data !== 32'h0) begin n_fail++; $display("FAIL ar_data: got %h want 0", d3_data); end
    n_checks++; if (d3_cnt !== 16'h0) begin n_fail++; $display("FAIL ar_cnt: got %h want 0", d3_cnt); end
    #1 rst = 1'b0;
    drive(1'b1, 16'h0440, 32'h40); tick();
    n_checks++; if (d3_valid !== 1'b0) begin n_fail++; $display("FAIL ar_empty_valid: got %b want 0", d3_valid); end
    n_checks++; if (d3_cnt !== 16'h1) begin n_fail++; $display("FAIL ar_first_cnt: got %0d want 1", d3_cnt); end
    drive(1'b1, 16'h0441, 32'h41); tick();
    drive(1'b1, 16'h0442, 32'h42); tick();
    n_checks++; if (d3_data !== 32'h40) begin n_fail++; $display("FAIL ar_resume_data: got %h want 40", d3_data); end
    n_checks++; if (d3_ctrl !== 16'h0440) begin n_fail++; $display("FAIL ar_resume_ctrl: got %h want 0440", d3_ctrl); end
  endtask

  initial begin
    test_reset();
    test_streaming();
    test_stall();
    test_flush_stall();
    test_flush_timing();
    test_flush_all();
    test_cnt_saturation();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
